uart_tx_serializer: RTL

UART transmit stage: accepts a parallel byte on a single-cycle request and serializes it onto the `tx` line as start bit, data bits LSB-first, an optional even-parity bit, and a stop bit. Each bit lasts `CLKS_PER_BIT` clocks. It sits beside the receive path inside the UART top, driven by `tx_data`/`tx_send` from the host side, with `tx` going to the pad. It is the transmit-side counterpart of the receive shifter and counters.

---
 rtl/uart_tx_serializer_pkg.sv | 16 +
 rtl/uart_tx_serializer_tx_shifter.sv | 79 +++++++
 rtl/uart_tx_serializer.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/uart_tx_serializer_pkg.sv
// Shared UART transmit types and defaults: frame width, clocks per bit and the
// transmit state encoding used by uart_tx_serializer.
package UART_MIKE_pkg;

  localparam int UART_DATA_WIDTH = 8;
  localparam int TX_CLOCK_WIDTH  = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

endpackage

// File: rtl/uart_tx_serializer_tx_shifter.sv
// Transmit load/shift register, LSB-first; even parity of the loaded value is
// captured at load time when UART_TX_PARITY_EN is defined.
module tx_shifter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         bit0,
`ifdef UART_TX_PARITY_EN
  output logic         parity,
`endif
  output logic         bit_next
);

  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  // next shift-register contents: load wins over shift
  always_comb begin
    data_d = data_q;
    if (load) begin
      data_d = din;
    end else if (shift) begin
      data_d = data_q >> 1'b1;
    end else begin
      data_d = data_q;
    end
  end

  // shift-register storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign bit0 = data_q[0];

  // bit that becomes bit0 after a shift, so the caller can register it early
  generate
    if (W > 1) begin : g_next_wide
      assign bit_next = data_q[1];
    end else begin : g_next_single
      assign bit_next = 1'b0;
    end
  endgenerate

`ifdef UART_TX_PARITY_EN
  logic parity_q;
  logic parity_d;

  // parity is taken from din so it survives the shifting of data_q
  always_comb begin
    parity_d = parity_q;
    if (load) begin
      parity_d = ^din;
    end else begin
      parity_d = parity_q;
    end
  end

  // parity storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end

  assign parity = parity_q;
`endif

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start, LSB-first data, optional even parity
// (UART_TX_PARITY_EN) and stop bit, each CLKS_PER_BIT clocks long.
module uart_tx_serializer #(
  parameter int UART_DATA_WIDTH = UART_MIKE_pkg::UART_DATA_WIDTH,
  parameter int CLKS_PER_BIT    = UART_MIKE_pkg::TX_CLOCK_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [UART_DATA_WIDTH-1:0] tx_data,
  input  logic                       tx_send,
  output logic                       tx,
  output logic                       tx_busy,
  output logic                       tx_done
);

  import UART_MIKE_pkg::*;

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(UART_DATA_WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(UART_DATA_WIDTH - 1);

  tx_state_t     state_q, state_d;
  logic [CW-1:0] clk_cnt_q, clk_cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic load_s;
  logic shift_s;
  logic bit0_s;
  logic bit_next_s;
  logic bit_end_s;
`ifdef UART_TX_PARITY_EN
  logic parity_s;
`endif

  tx_shifter #(
    .W(UART_DATA_WIDTH)
  ) u_shifter (
    .clk     (clk),
    .rst     (rst),
    .load    (load_s),
    .shift   (shift_s),
    .din     (tx_data),
    .bit0    (bit0_s),
`ifdef UART_TX_PARITY_EN
    .parity  (parity_s),
`endif
    .bit_next(bit_next_s)
  );

  assign bit_end_s = (clk_cnt_q == CNT_LAST);

  // next-state logic; tx_d is the line value for the state being entered
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    idx_d     = idx_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    load_s    = 1'b0;
    shift_s   = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (tx_send) begin
          load_s    = 1'b1;
          clk_cnt_d = '0;
          idx_d     = '0;
          state_d   = START;
          tx_d      = 1'b0;
          busy_d    = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (bit_end_s) begin
          clk_cnt_d = '0;
          state_d   = DATA;
          tx_d      = bit0_s;
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (bit_end_s) begin
          clk_cnt_d = '0;
          shift_s   = 1'b1;
          idx_d     = idx_q + IW'(1);
          if (idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = parity_s;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            tx_d = bit_next_s;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end_s) begin
          clk_cnt_d = '0;
          state_d   = STOP;
          tx_d      = 1'b1;
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end
`endif
      STOP: begin
        if (bit_end_s) begin
          clk_cnt_d = '0;
          state_d   = IDLE;
          tx_d      = 1'b1;
          busy_d    = 1'b0;
          done_d    = 1'b1;
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        clk_cnt_d = '0;
        idx_d     = '0;
        tx_d      = 1'b1;
        busy_d    = 1'b0;
      end
    endcase
  end

  // FSM, counters and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      idx_q     <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      idx_q     <= idx_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign tx      = tx_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule
